// File: rtl/onekiwi_seq_if.sv
// Bus bundle between the onekiwi sequencer and its ROM / ALU / debug environment.
// The master view belongs to the sequencer; the slave view belongs to the surroundings.
interface onekiwi_seq_if;
  logic       tick;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       rom_valid;
  logic [3:0] cmd;
  logic [3:0] imd;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic       alu_nrst;
  logic       wa;
  logic       wb;
  logic       wo;
  logic       jump;
  logic       co;
  logic [3:0] data;
  logic [3:0] out_port;
  logic       out_stb;
  logic [3:0] pc;
  logic [1:0] state;

  modport master (
    input  tick, rom_data, rom_valid, wa, wb, wo, jump, co, data,
    output rom_addr, cmd, imd, a, b, ci, alu_nrst, out_port, out_stb, pc, state
  );

  modport slave (
    output tick, rom_data, rom_valid, wa, wb, wo, jump, co, data,
    input  rom_addr, cmd, imd, a, b, ci, alu_nrst, out_port, out_stb, pc, state
  );
endinterface

// File: rtl/onekiwi_seq.sv
// Fetch / wait / execute sequencer for a 4-bit TD4-style CPU: fetches one ROM word per
// accepted tick, hands the latched instruction to an external ALU and commits its results.
module onekiwi_seq (
  input  logic             clk,
  input  logic             rst,
  onekiwi_seq_if.master    bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_EXEC  = 2'b10,
    ST_ILL   = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       ci_q, ci_d;
  logic       stb_q, stb_d;
  logic       nrst_q, nrst_d;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and commit logic; ALU strobes only matter in EXEC
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    ci_d    = ci_q;
    stb_d   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.tick) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (bus.rom_valid) begin
          ir_d    = bus.rom_data;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (bus.wa) begin
          a_d = bus.data;
        end else begin
          a_d = a_q;
        end
        if (bus.wb) begin
          b_d = bus.data;
        end else begin
          b_d = b_q;
        end
        if (bus.wo) begin
          out_d = bus.data;
          stb_d = 1'b1;
        end else begin
          out_d = out_q;
          stb_d = 1'b0;
        end
        ci_d = bus.co;
        if (bus.jump) begin
          pc_d = bus.data;
        end else begin
          pc_d = pc_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    nrst_d = (state_d == ST_EXEC);
  end

  // Architectural registers; reset wins over any pending commit
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q   <= 8'h00;
      pc_q   <= 4'h0;
      a_q    <= 4'h0;
      b_q    <= 4'h0;
      out_q  <= 4'h0;
      ci_q   <= 1'b0;
      stb_q  <= 1'b0;
      nrst_q <= 1'b0;
    end else begin
      ir_q   <= ir_d;
      pc_q   <= pc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      out_q  <= out_d;
      ci_q   <= ci_d;
      stb_q  <= stb_d;
      nrst_q <= nrst_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.cmd      = ir_q[7:4];
  assign bus.imd      = ir_q[3:0];
  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.ci       = ci_q;
  assign bus.alu_nrst = nrst_q;
  assign bus.out_port = out_q;
  assign bus.out_stb  = stb_q;
  assign bus.pc       = pc_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_onekiwi_seq.sv
// Self-checking bench for onekiwi_seq: directed TD4 programs through a bench-side ALU,
// then randomized stimulus, all compared every cycle against an instruction-level model.
module tb_onekiwi_seq;

  logic clk;
  logic rst;
  onekiwi_seq_if bus ();

  onekiwi_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rom [16];

  // Reference model: phase 0 idle/fetch, 1 waiting for ROM, 2 executing
  logic [1:0] m_ph   = 2'd0;
  logic [7:0] m_ir   = 8'h00;
  logic [3:0] m_pc   = 4'h0;
  logic [3:0] m_a    = 4'h0;
  logic [3:0] m_b    = 4'h0;
  logic [3:0] m_out  = 4'h0;
  logic       m_ci   = 1'b0;
  logic       m_stb  = 1'b0;
  logic       m_live = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model: one accepted tick, one ROM word, one committed instruction
  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 2'd0; m_ir <= 8'h00; m_pc <= 4'h0; m_a <= 4'h0; m_b <= 4'h0;
      m_out <= 4'h0; m_ci <= 1'b0; m_stb <= 1'b0; m_live <= 1'b1;
    end else begin
      m_stb <= 1'b0;
      if (m_ph == 2'd0 && bus.tick) begin
        m_ph <= 2'd1;
      end else if (m_ph == 2'd1 && bus.rom_valid) begin
        m_ir <= bus.rom_data;
        m_ph <= 2'd2;
      end else if (m_ph == 2'd2) begin
        if (bus.wa) m_a <= bus.data;
        if (bus.wb) m_b <= bus.data;
        if (bus.wo) begin
          m_out <= bus.data;
          m_stb <= 1'b1;
        end
        m_ci <= bus.co;
        m_pc <= bus.jump ? bus.data : 4'(m_pc + 4'd1);
        m_ph <= 2'd0;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("state",    32'(bus.state),    32'(m_ph));
      chk("pc",       32'(bus.pc),       32'(m_pc));
      chk("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
      chk("cmd",      32'(bus.cmd),      32'(m_ir[7:4]));
      chk("imd",      32'(bus.imd),      32'(m_ir[3:0]));
      chk("a",        32'(bus.a),        32'(m_a));
      chk("b",        32'(bus.b),        32'(m_b));
      chk("ci",       32'(bus.ci),       32'(m_ci));
      chk("alu_nrst", 32'(bus.alu_nrst), 32'(m_ph == 2'd2));
      chk("out_port", 32'(bus.out_port), 32'(m_out));
      chk("out_stb",  32'(bus.out_stb),  32'(m_stb));
    end
  end

  // TD4-style ALU driven from the sequencer's current outputs
  task automatic alu();
    logic [4:0] s;
    bus.wa = 1'b0; bus.wb = 1'b0; bus.wo = 1'b0; bus.jump = 1'b0; bus.co = 1'b0;
    bus.data = 4'h0;
    case (bus.cmd)
      4'h0: begin s = 5'(bus.a) + 5'(bus.imd); bus.data = s[3:0]; bus.co = s[4]; bus.wa = 1'b1; end
      4'h1: begin bus.data = bus.b;   bus.wa = 1'b1; end
      4'h3: begin bus.data = bus.imd; bus.wa = 1'b1; end
      4'h4: begin bus.data = bus.a;   bus.wb = 1'b1; end
      4'h5: begin s = 5'(bus.b) + 5'(bus.imd); bus.data = s[3:0]; bus.co = s[4]; bus.wb = 1'b1; end
      4'h7: begin bus.data = bus.imd; bus.wb = 1'b1; end
      4'h9: begin bus.data = bus.b;   bus.wo = 1'b1; end
      4'hB: begin bus.data = bus.imd; bus.wo = 1'b1; end
      4'hE: begin bus.data = bus.imd; bus.jump = ~bus.ci; end
      4'hF: begin bus.data = bus.imd; bus.jump = 1'b1; end
      default: bus.data = 4'h0;
    endcase
  endtask

  task automatic step(input logic t, input logic v, input logic r);
    bus.tick = t;
    bus.rom_valid = v;
    rst = r;
    bus.rom_data = v ? rom[bus.rom_addr] : 8'($urandom);
    alu();
    @(negedge clk);
  endtask

  task automatic run_instr();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic rand_step();
    bus.tick      = 1'($urandom_range(0, 1));
    bus.rom_valid = 1'($urandom_range(0, 1));
    bus.rom_data  = 8'($urandom);
    bus.wa        = 1'($urandom_range(0, 1));
    bus.wb        = 1'($urandom_range(0, 1));
    bus.wo        = 1'($urandom_range(0, 1));
    bus.jump      = 1'($urandom_range(0, 1));
    bus.co        = 1'($urandom_range(0, 1));
    bus.data      = 4'($urandom);
    rst           = ($urandom_range(0, 63) == 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.tick = 1'b0; bus.rom_valid = 1'b0; bus.rom_data = 8'h00;
    bus.wa = 1'b0; bus.wb = 1'b0; bus.wo = 1'b0; bus.jump = 1'b0; bus.co = 1'b0;
    bus.data = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_nrst", 32'(bus.alu_nrst), 32'd0);

    // MVAI 3 ; ADAI 2
    rom[0] = 8'h33; rom[1] = 8'h02;
    run_instr(); run_instr();
    chk("seq_a5", 32'(bus.a), 32'd5);
    chk("seq_ci0", 32'(bus.ci), 32'd0);
    chk("seq_pc2", 32'(bus.pc), 32'd2);

    // MVBI 9 ; MVAI F ; ADAI 1 (carry out) ; MVBI 0 (carry cleared)
    rom[2] = 8'h79; rom[3] = 8'h3F; rom[4] = 8'h01; rom[5] = 8'h70;
    run_instr(); run_instr(); run_instr();
    chk("add_wrap_a", 32'(bus.a), 32'd0);
    chk("add_wrap_ci", 32'(bus.ci), 32'd1);
    chk("add_wrap_b", 32'(bus.b), 32'd9);
    run_instr();
    chk("mvbi_b", 32'(bus.b), 32'd0);
    chk("mvbi_ci", 32'(bus.ci), 32'd0);

    // OUTI A
    rom[6] = 8'hBA;
    run_instr();
    chk("outi_port", 32'(bus.out_port), 32'hA);
    chk("outi_stb1", 32'(bus.out_stb), 32'd1);
    chk("outi_a", 32'(bus.a), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("outi_stb0", 32'(bus.out_stb), 32'd0);

    // Conditional and unconditional jumps, pc wrap
    rom[7] = 8'h3F; rom[8] = 8'h01; rom[9] = 8'hE7; rom[10] = 8'hE7;
    run_instr(); run_instr();
    chk("jnc_pre_ci", 32'(bus.ci), 32'd1);
    run_instr();
    chk("jnc_taken_no", 32'(bus.pc), 32'd10);
    run_instr();
    chk("jnc_taken", 32'(bus.pc), 32'd7);
    rom[7] = 8'hFF;
    run_instr();
    chk("jmp_f", 32'(bus.pc), 32'd15);
    rom[15] = 8'hF0;
    run_instr();
    chk("jmp_0", 32'(bus.pc), 32'd0);
    rom[0] = 8'hFF;
    run_instr();
    rom[15] = 8'h32;
    run_instr();
    chk("pc_wrap", 32'(bus.pc), 32'd0);
    chk("pc_wrap_a", 32'(bus.a), 32'd2);

    // ROM stall with extra ticks
    rom[0] = 8'h34;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    chk("stall_state", 32'(bus.state), 32'd1);
    chk("stall_a", 32'(bus.a), 32'd2);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("stall_exec_a", 32'(bus.a), 32'd4);
    chk("stall_exec_pc", 32'(bus.pc), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("stall_once", 32'(bus.state), 32'd0);

    // Reset during EXEC of ADAI with a=3
    rom[1] = 8'h33; rom[2] = 8'h05;
    run_instr();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_exec", 32'(bus.alu_nrst), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_exec_a", 32'(bus.a), 32'd0);
    chk("rst_exec_pc", 32'(bus.pc), 32'd0);
    chk("rst_exec_state", 32'(bus.state), 32'd0);
    chk("rst_exec_out", 32'(bus.out_port), 32'd0);
    chk("rst_exec_cmd", 32'(bus.cmd), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("post_rst_addr", 32'(bus.rom_addr), 32'd0);
    chk("post_rst_wait", 32'(bus.state), 32'd1);

    for (int i = 0; i < 3000; i++) rand_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/onekiwi_seq.md
ONEKIWI_SEQ -- requirements
Module: onekiwi_seq

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset, listed first: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have: tick  in  1  instruction-advance enable (one-cycle pulse from clock divider).
REQ-003 The block SHALL have: rom_addr  out  4  fetch address; rom_data  in  8  instruction {cmd[7:4], imd[3:0]}; rom_valid  in  1  rom_data valid for current rom_addr.
REQ-004 The block SHALL have: cmd  out  4  and imd  out  4  latched instruction fields to the ALU; a  out  4, b  out  4  register values; ci  out  1  carry flag; alu_nrst  out  1  ALU enable (high only in EXEC).
REQ-005 The block SHALL have: wa, wb, wo, jump, co  in  1 each; data  in  4  ALU results.
REQ-006 The block SHALL have: out_port  out  4  output register; out_stb  out  1  one-cycle pulse when out_port is written; pc  out  4  program counter; state  out  2  debug FSM state.

Function
REQ-007 The FSM SHALL have states FETCH=2'b00, WAIT=2'b01, EXEC=2'b10; 2'b11 SHALL return to FETCH next cycle with no register writes.
REQ-008 FETCH: rom_addr SHALL equal pc; on tick=1 go to WAIT, else stay.
REQ-009 WAIT: rom_addr SHALL equal pc; when rom_valid=1 latch rom_data into IR (cmd=IR[7:4], imd=IR[3:0]) and go to EXEC; else stay (no timeout).
REQ-010 EXEC: alu_nrst SHALL be 1 (0 in all other states); commit occurs on the EXEC cycle edge; next state FETCH.
REQ-011 Commit: wa=1 -> a<=data; wb=1 -> b<=data; wo=1 -> out_port<=data and out_stb=1 for exactly the following cycle.
REQ-012 Commit: ci<=co on every executed instruction (non-add instructions clear carry, since ALU drives co=0).
REQ-013 Commit: jump=1 -> pc<=data; else pc<=pc+1 mod 16 (15 wraps to 0).
REQ-014 Simultaneous wa and wb asserted (illegal from ALU) SHALL write both; wa/wb/wo/jump sampled outside EXEC SHALL be ignored.
REQ-015 tick pulses arriving in WAIT or EXEC SHALL be ignored (not queued); at most one instruction per accepted tick.
REQ-016 cmd/imd SHALL remain stable from IR latch until the next IR latch.
REQ-017 Minimum instruction latency SHALL be 3 cycles (FETCH with tick, WAIT with rom_valid, EXEC).

Reset
REQ-018 rst=1 at a clock edge SHALL force state=FETCH, pc=0, a=0, b=0, ci=0, out_port=0, out_stb=0, IR=8'h00, alu_nrst=0, regardless of state.
REQ-019 rst asserted during EXEC SHALL suppress that cycle's commit entirely (reset takes priority).
REQ-020 First fetch after rst release SHALL read address 0 on the first accepted tick.

Verification
REQ-021 ROM {0:8'h33 MVAI 3, 1:8'h02 ADAI 2}, tick each cycle, rom_valid=1 -> after 2 instructions a=5, ci=0, pc=2.
REQ-022 a=4'hF then ADAI 1 -> a=0, ci=1; next MVBI 0 -> b=0, ci=0.
REQ-023 OUTI 4'hA (8'hBA) -> out_port=4'hA, out_stb high exactly one cycle; a,b unchanged.
REQ-024 ci=1 then JNCI 4'h7 -> pc=prev+1; ci=0 then JNCI 4'h7 -> pc=7; JMPI 4'h0 at pc=15 -> pc=0; plain instruction at pc=15 -> pc=0.
REQ-025 rom_valid held low 5 cycles in WAIT, extra tick pulses injected -> state stays WAIT, no writes; on rom_valid=1 exactly one instruction executes.
REQ-026 rst pulsed in EXEC of ADAI with a=3 -> no commit; all registers 0, state FETCH next cycle.
